i2s_tx_clkgen: RTL and testbench

Upstream companion of the I2S serializer. Divides the master clock into the serial bit clock and the word-select clock. Issues the one-cycle-early edge strobes the serializer uses to time its shifts and loads. Buffers stereo frames from the audio datapath in a small FIFO and presents one left/right pair per frame on the serializer's parallel inputs.

---
 rtl/i2s_tx_clkgen.sv | 166 ++++++++++++++++
 tb/tb_i2s_tx_clkgen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_clkgen.sv
// I2S transmit clock generator: derives sclk/lrclk from mclk, issues one-cycle-early
// edge strobes, and feeds one buffered stereo frame per lrclk period to the serializer.
module i2s_tx_clkgen #(
   parameter int DATA_RES       = 24,
   parameter int MCLK_PER_SCLK  = 4,
   parameter int SCLK_PER_FRAME = 64,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                            mclk,
   input  logic                            reset_n,
   input  logic                            i_en,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic [DATA_RES-1:0]             s_ldata,
   input  logic [DATA_RES-1:0]             s_rdata,
   output logic                            sclk,
   output logic                            lrclk,
   output logic                            next_sclk_rise,
   output logic                            next_sclk_fall,
   output logic                            next_lrclk_rise,
   output logic                            next_lrclk_fall,
   output logic [DATA_RES-1:0]             o_ldin,
   output logic [DATA_RES-1:0]             o_rdin,
   output logic [$clog2(FIFO_DEPTH):0]     o_level,
   output logic                            o_underrun,
   output logic [7:0]                      o_underrun_cnt
);

   // state | meaning
   // IDLE  | parked on the last mclk of a frame (sdiv=M-1, bcnt=F-1, sclk=0, lrclk=1)
   // RUN   | counters advancing, strobes active

   localparam int SW = $clog2(MCLK_PER_SCLK);
   localparam int BW = $clog2(SCLK_PER_FRAME);
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [SW-1:0] SDIV_LAST = SW'(MCLK_PER_SCLK - 1);
   localparam logic [SW-1:0] SDIV_HALF = SW'(MCLK_PER_SCLK / 2 - 1);
   localparam logic [BW-1:0] BCNT_LAST = BW'(SCLK_PER_FRAME - 1);
   localparam logic [BW-1:0] BCNT_HALF = BW'(SCLK_PER_FRAME / 2 - 1);
   localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state;
   logic [SW-1:0]   sdiv;
   logic [BW-1:0]   bcnt;
   logic            sdiv_last;
   logic            frame_end;

   always_comb begin
      sdiv_last       = (state == RUN) && (sdiv == SDIV_LAST);
      frame_end       = sdiv_last && (bcnt == BCNT_LAST);
      next_sclk_rise  = (state == RUN) && (sdiv == SDIV_HALF);
      next_sclk_fall  = sdiv_last || ((state == IDLE) && i_en);
      next_lrclk_rise = sdiv_last && (bcnt == BCNT_HALF);
      next_lrclk_fall = i_en && ((state == IDLE) || frame_end);
   end

   always_ff @(posedge mclk) begin
      if (!reset_n) begin
         state <= IDLE;
         sdiv  <= SDIV_LAST;
         bcnt  <= BCNT_LAST;
         sclk  <= 1'b0;
         lrclk <= 1'b1;
      end else begin
         if (next_sclk_rise)
            sclk <= 1'b1;
         else if (next_sclk_fall)
            sclk <= 1'b0;

         if (next_lrclk_fall)
            lrclk <= 1'b0;
         else if (next_lrclk_rise)
            lrclk <= 1'b1;

         case (state)
            IDLE: begin
               if (i_en) begin
                  state <= RUN;
                  sdiv  <= '0;
                  bcnt  <= '0;
               end
            end
            RUN: begin
               if (frame_end) begin
                  // without i_en the counters simply stay parked at the frame end
                  if (i_en) begin
                     sdiv <= '0;
                     bcnt <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else if (sdiv_last) begin
                  sdiv <= '0;
                  bcnt <= bcnt + BW'(1);
               end else begin
                  sdiv <= sdiv + SW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [DATA_RES-1:0] mem_l [FIFO_DEPTH];
   logic [DATA_RES-1:0] mem_r [FIFO_DEPTH];
   logic [AW-1:0]       wptr;
   logic [AW-1:0]       rptr;
   logic [AW:0]         count;
   logic                push;
   logic                pop_ok;
   logic                fifo_empty;

   always_comb begin
      fifo_empty = (count == '0);
      s_ready    = reset_n && (count != FIFO_FULL);
      push       = s_valid && s_ready;
      pop_ok     = next_lrclk_fall && !fifo_empty;
      o_level    = count;
   end

   always_ff @(posedge mclk) begin
      if (push) begin
         mem_l[wptr] <= s_ldata;
         mem_r[wptr] <= s_rdata;
      end
   end

   always_ff @(posedge mclk) begin
      if (!reset_n) begin
         wptr           <= '0;
         rptr           <= '0;
         count          <= '0;
         o_ldin         <= '0;
         o_rdin         <= '0;
         o_underrun     <= 1'b0;
         o_underrun_cnt <= 8'd0;
      end else begin
         if (push)
            wptr <= wptr + AW'(1);

         // a push landing in the pop cycle is not bypassed; an empty pop mutes the frame
         if (pop_ok) begin
            o_ldin <= mem_l[rptr];
            o_rdin <= mem_r[rptr];
            rptr   <= rptr + AW'(1);
         end else if (next_lrclk_fall) begin
            o_ldin <= '0;
            o_rdin <= '0;
         end

         o_underrun <= next_lrclk_fall && fifo_empty;
         if (next_lrclk_fall && fifo_empty && (o_underrun_cnt != 8'hFF))
            o_underrun_cnt <= o_underrun_cnt + 8'd1;

         case ({push, pop_ok})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_i2s_tx_clkgen.sv
// Randomized bench for i2s_tx_clkgen against a frame-position / queue reference model.
module tb_i2s_tx_clkgen;
   localparam int DR = 24;
   localparam int M  = 4;
   localparam int F  = 64;
   localparam int D  = 4;
   localparam int MF = M * F;
   localparam int LW = $clog2(D) + 1;

   logic          mclk = 1'b0;
   logic          reset_n, i_en, s_valid, s_ready;
   logic [DR-1:0] s_ldata, s_rdata, o_ldin, o_rdin;
   logic          sclk, lrclk, nsr, nsf, nlr, nlf;
   logic [LW-1:0] o_level;
   logic          o_underrun;
   logic [7:0]    o_underrun_cnt;

   i2s_tx_clkgen #(.DATA_RES(DR), .MCLK_PER_SCLK(M), .SCLK_PER_FRAME(F), .FIFO_DEPTH(D)) dut (
      .mclk(mclk), .reset_n(reset_n), .i_en(i_en), .s_valid(s_valid), .s_ready(s_ready),
      .s_ldata(s_ldata), .s_rdata(s_rdata), .sclk(sclk), .lrclk(lrclk),
      .next_sclk_rise(nsr), .next_sclk_fall(nsf), .next_lrclk_rise(nlr), .next_lrclk_fall(nlf),
      .o_ldin(o_ldin), .o_rdin(o_rdin), .o_level(o_level), .o_underrun(o_underrun),
      .o_underrun_cnt(o_underrun_cnt)
   );

   always #5 mclk = ~mclk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // model: m_t is the mclk position inside the current frame (0 = first cycle with lrclk low)
   bit            m_run = 0;
   int            m_t = MF - 1;
   logic [DR-1:0] q_l[$];
   logic [DR-1:0] q_r[$];
   logic [DR-1:0] m_l = '0, m_r = '0;
   bit            m_ur = 0;
   int            m_cnt = 0;

   task automatic cyc(input bit rn, input bit en, input bit v, input logic [DR-1:0] l,
                      input logic [DR-1:0] r);
      bit e_sr, e_sf, e_lr, e_lf, do_push;
      @(posedge mclk);
      #1;
      chk("sclk",  sclk,  m_run && ((m_t % M) >= M / 2));
      chk("lrclk", lrclk, m_run ? (m_t >= MF / 2) : 1'b1);
      chk("ldin",  o_ldin, m_l);
      chk("rdin",  o_rdin, m_r);
      chk("level", o_level, q_l.size());
      chk("urun",  o_underrun, m_ur);
      chk("ucnt",  o_underrun_cnt, m_cnt);

      reset_n = rn; i_en = en; s_valid = v; s_ldata = l; s_rdata = r;
      #1;
      e_sr = m_run && ((m_t % M) == M / 2 - 1);
      e_sf = m_run ? ((m_t % M) == M - 1) : en;
      e_lr = m_run && (m_t == MF / 2 - 1);
      e_lf = en && (!m_run || m_t == MF - 1);
      chk("ready", s_ready, rn && (q_l.size() < D));
      if (rn)
         chk("strobes", {nsr, nsf, nlr, nlf}, {e_sr, e_sf, e_lr, e_lf});

      if (!rn) begin
         m_run = 0; m_t = MF - 1; q_l.delete(); q_r.delete();
         m_l = '0; m_r = '0; m_ur = 0; m_cnt = 0;
      end else begin
         do_push = v && (q_l.size() < D);
         m_ur = 0;
         if (e_lf) begin
            if (q_l.size() > 0) begin
               m_l = q_l.pop_front();
               m_r = q_r.pop_front();
            end else begin
               m_l = '0; m_r = '0; m_ur = 1;
               if (m_cnt < 255) m_cnt++;
            end
         end
         if (do_push) begin
            q_l.push_back(l);
            q_r.push_back(r);
         end
         if (!m_run) begin
            if (en) begin m_run = 1; m_t = 0; end
         end else if (m_t == MF - 1) begin
            if (en) m_t = 0;
            else m_run = 0;
         end else begin
            m_t++;
         end
      end
   endtask

   task automatic wait_t(input int target);
      bit hit = 0;
      for (int i = 0; i < 3 * MF; i++) begin
         if (m_run && m_t == target) begin hit = 1; break; end
         cyc(1, 1, 0, '0, '0);
      end
      chk("wait_t", hit, 1'b1);
   endtask

   initial begin
      #(10 * 60000);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit en_r;
      bit idle_hit;
      reset_n = 0; i_en = 0; s_valid = 0; s_ldata = '0; s_rdata = '0;
      repeat (3) cyc(0, 0, 0, '0, '0);
      repeat (5) cyc(1, 0, 0, '0, '0);

      // enable with empty FIFO, run two frames with underruns
      repeat (2 * MF + 10) cyc(1, 1, 0, '0, '0);

      // fill: four accepted, fifth refused
      wait_t(20);
      for (int k = 0; k < 5; k++)
         cyc(1, 1, 1, DR'(32'hA00001 + k), DR'(32'h500001 + k));
      cyc(1, 1, 0, '0, '0);
      chk("fill_level", o_level, 4);
      chk("fill_ready", s_ready, 0);
      wait_t(0);
      cyc(1, 1, 0, '0, '0);
      chk("first_l", o_ldin, 24'hA00001);
      chk("first_r", o_rdin, 24'h500001);
      chk("first_lvl", o_level, 3);
      chk("first_rdy", s_ready, 1);

      // streaming with random pushes
      repeat (12 * MF)
         cyc(1, 1, ($urandom % 90) == 0, DR'($urandom), DR'($urandom));

      // graceful stop at bcnt=10, idle 20 cycles, re-enable
      wait_t(10 * M);
      idle_hit = 0;
      for (int i = 0; i < 2 * MF; i++) begin
         if (!m_run) begin idle_hit = 1; break; end
         cyc(1, 0, 0, '0, '0);
      end
      chk("stop_idle", idle_hit, 1'b1);
      repeat (20) cyc(1, 0, 0, '0, '0);
      cyc(1, 1, 0, '0, '0);
      repeat (MF) cyc(1, 1, 0, '0, '0);

      // stop cancelled before frame end
      wait_t(30 * M);
      repeat (100) cyc(1, 0, 0, '0, '0);
      repeat (MF) cyc(1, 1, 0, '0, '0);

      // reset at bcnt=40 with two frames buffered
      repeat (2) cyc(0, 0, 0, '0, '0);
      cyc(1, 1, 0, '0, '0);
      cyc(1, 1, 1, DR'(32'h111111), DR'(32'h222222));
      cyc(1, 1, 1, DR'(32'h333333), DR'(32'h444444));
      wait_t(40 * M);
      chk("pre_rst_lvl", o_level, 2);
      cyc(0, 1, 0, '0, '0);
      cyc(1, 0, 0, '0, '0);
      chk("rst_lvl", o_level, 0);
      chk("rst_ucnt", o_underrun_cnt, 0);
      chk("rst_lrclk", lrclk, 1);
      chk("rst_sclk", sclk, 0);

      // random enable / push / rare reset
      en_r = 1;
      for (int i = 0; i < 8 * MF; i++) begin
         if (($urandom % 300) == 0) en_r = !en_r;
         cyc(($urandom % 3000) != 0, en_r, ($urandom % 60) == 0, DR'($urandom), DR'($urandom));
      end
      cyc(1, 1, 0, '0, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
